reg_file_ctrl: RTL and testbench

Command sequencer that drives the write port and both read ports of the 16x16 register file and returns read data to the requester. Accepts READ, WRITE, SWAP and CLEAR commands over a valid/ready handshake and turns each into a timed sequence of register-file port activity. All register-file port drives are registered. The block sits between the datapath control logic and the register file.

---
 rtl/reg_file_ctrl.sv | 124 ++++++++++++
 tb/tb_reg_file_ctrl.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_ctrl.sv
// Command sequencer for a 16x16 register file: turns READ/WRITE/SWAP/CLEAR
// commands into registered write-port and read-address activity, returns READ data.
module reg_file_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [3:0]  cmd_a,
  input  logic [3:0]  cmd_b,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic [15:0] rsp_data1,
  output logic [15:0] rsp_data2,
  output logic        rf_wen,
  output logic [3:0]  rf_wadr,
  output logic [15:0] rf_din,
  output logic [3:0]  rf_radr1,
  output logic [3:0]  rf_radr2,
  input  logic [15:0] rf_out1,
  input  logic [15:0] rf_out2
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SWAP  = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD      = 3'd1,
    SW_W1   = 3'd2,
    SW_W2   = 3'd3,
    SW_FIN  = 3'd4,
    CLR     = 3'd5,
    CLR_FIN = 3'd6
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [15:0] tmp;

  assign cmd_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rsp_valid <= 1'b0;
      rsp_data1 <= '0;
      rsp_data2 <= '0;
      rf_wen    <= 1'b0;
      rf_wadr   <= '0;
      rf_din    <= '0;
      rf_radr1  <= '0;
      rf_radr2  <= '0;
      cnt       <= '0;
      tmp       <= '0;
    end else begin
      rf_wen    <= 1'b0;
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_READ: begin
                rf_radr1 <= cmd_a;
                rf_radr2 <= cmd_b;
                state    <= RD;
              end
              OP_WRITE: begin
                rf_wen  <= 1'b1;
                rf_wadr <= cmd_a;
                rf_din  <= cmd_data;
              end
              OP_SWAP: begin
                rf_radr1 <= cmd_a;
                rf_radr2 <= cmd_b;
                state    <= SW_W1;
              end
              default: begin
                rf_wen  <= 1'b1;
                rf_wadr <= 4'd0;
                rf_din  <= '0;
                cnt     <= 4'd1;
                state   <= CLR;
              end
            endcase
          end
        end
        RD: begin
          rsp_data1 <= rf_out1;
          rsp_data2 <= rf_out2;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        // Read addresses still hold a/b, so they double as the swap write targets.
        SW_W1: begin
          tmp     <= rf_out1;
          rf_wen  <= 1'b1;
          rf_wadr <= rf_radr1;
          rf_din  <= rf_out2;
          state   <= SW_W2;
        end
        SW_W2: begin
          rf_wen  <= 1'b1;
          rf_wadr <= rf_radr2;
          rf_din  <= tmp;
          state   <= SW_FIN;
        end
        SW_FIN: state <= IDLE;
        CLR: begin
          rf_wen  <= 1'b1;
          rf_wadr <= cnt;
          rf_din  <= '0;
          cnt     <= cnt + 4'd1;
          if (cnt == 4'd15) state <= CLR_FIN;
        end
        CLR_FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_ctrl.sv
// Directed bench for reg_file_ctrl with a behavioural 16x16 register file attached.
module tb_reg_file_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [3:0]  cmd_a;
  logic [3:0]  cmd_b;
  logic [15:0] cmd_data;
  logic        rsp_valid;
  logic [15:0] rsp_data1;
  logic [15:0] rsp_data2;
  logic        rf_wen;
  logic [3:0]  rf_wadr;
  logic [15:0] rf_din;
  logic [3:0]  rf_radr1;
  logic [3:0]  rf_radr2;
  logic [15:0] rf_out1;
  logic [15:0] rf_out2;

  logic [15:0] rf [16] = '{default: 16'h0000};

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (rf_wen) rf[rf_wadr] <= rf_din;
  assign rf_out1 = rf[rf_radr1];
  assign rf_out2 = rf[rf_radr2];

  reg_file_ctrl dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data1(rsp_data1), .rsp_data2(rsp_data2),
    .rf_wen(rf_wen), .rf_wadr(rf_wadr), .rf_din(rf_din),
    .rf_radr1(rf_radr1), .rf_radr2(rf_radr2),
    .rf_out1(rf_out1), .rf_out2(rf_out2)
  );

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic send_cmd(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [15:0] d);
    int w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready_timeout: cmd_ready=%b required 1", cmd_ready);
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_data = d;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [3:0] b,
                         output logic [15:0] d1, output logic [15:0] d2);
    logic got = 1'b0;
    d1 = 'x;
    d2 = 'x;
    send_cmd(2'b00, a, b, 16'h0);
    for (int i = 0; i < 4 && !got; i++) begin
      if (rsp_valid === 1'b1) begin
        got = 1'b1;
        d1 = rsp_data1;
        d2 = rsp_data2;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_a = 4'h0; cmd_b = 4'h0; cmd_data = 16'h0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rf_wen} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_ctrl: ready/rsp_valid/wen=%b required 100", {cmd_ready, rsp_valid, rf_wen});
    end
    n_cmp++;
    if ({rsp_data1, rsp_data2, rf_din, rf_wadr, rf_radr1, rf_radr2} !== 60'h0) begin
      n_err++;
      $display("FAIL reset_data: d1=%h d2=%h din=%h wadr=%h radr=%h/%h required all 0",
               rsp_data1, rsp_data2, rf_din, rf_wadr, rf_radr1, rf_radr2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_read_basic;
    send_cmd(2'b00, 4'd3, 4'd7, 16'h0);
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL read_e0: ready/rsp_valid=%b required 00", {cmd_ready, rsp_valid});
    end
    n_cmp++;
    if ({rf_radr1, rf_radr2} !== 8'h37) begin
      n_err++;
      $display("FAIL read_radr: radr1/radr2=%h required 37", {rf_radr1, rf_radr2});
    end
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid} !== 2'b11) begin
      n_err++;
      $display("FAIL read_e1: ready/rsp_valid=%b required 11", {cmd_ready, rsp_valid});
    end
    n_cmp++;
    if ({rsp_data1, rsp_data2} !== 32'h0) begin
      n_err++;
      $display("FAIL read_data: d1=%h d2=%h required 0000 0000", rsp_data1, rsp_data2);
    end
    @(negedge clk);
    n_cmp++;
    if (rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL read_pulse: rsp_valid=%b required 0", rsp_valid);
    end
  endtask

  task automatic test_write_then_read;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_a = 4'd5; cmd_b = 4'd0; cmd_data = 16'hBEEF;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rf_wen, rf_wadr, rf_din} !== {1'b1, 1'b1, 4'd5, 16'hBEEF}) begin
      n_err++;
      $display("FAIL write_port: ready=%b wen=%b wadr=%h din=%h required 1 1 5 beef",
               cmd_ready, rf_wen, rf_wadr, rf_din);
    end
    cmd_op = 2'b00; cmd_a = 4'd5; cmd_b = 4'd5;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({rsp_valid, rsp_data1, rsp_data2} !== {1'b1, 16'hBEEF, 16'hBEEF}) begin
      n_err++;
      $display("FAIL write_read_b2b: valid=%b d1=%h d2=%h required 1 beef beef",
               rsp_valid, rsp_data1, rsp_data2);
    end
  endtask

  task automatic test_swap;
    logic [15:0] d1, d2;
    int lo = 0;
    send_cmd(2'b01, 4'd2, 4'd0, 16'h1111);
    send_cmd(2'b01, 4'd9, 4'd0, 16'h2222);
    send_cmd(2'b10, 4'd2, 4'd9, 16'h0);
    while (!cmd_ready && lo < 40) begin
      lo++;
      @(negedge clk);
    end
    n_cmp++;
    if (lo !== 3) begin
      n_err++;
      $display("FAIL swap_busy: ready low %0d cycles required 3", lo);
    end
    do_read(4'd2, 4'd9, d1, d2);
    n_cmp++;
    if ({d1, d2} !== {16'h2222, 16'h1111}) begin
      n_err++;
      $display("FAIL swap_result: R2=%h R9=%h required 2222 1111", d1, d2);
    end
    send_cmd(2'b01, 4'd4, 4'd0, 16'h00A5);
    send_cmd(2'b10, 4'd4, 4'd4, 16'h0);
    do_read(4'd4, 4'd4, d1, d2);
    n_cmp++;
    if ({d1, d2} !== {16'h00A5, 16'h00A5}) begin
      n_err++;
      $display("FAIL swap_same: R4=%h/%h required 00a5", d1, d2);
    end
  endtask

  task automatic test_clear;
    logic [15:0] d1, d2;
    for (int i = 0; i < 16; i++) send_cmd(2'b01, 4'(i), 4'd0, 16'hC000 + 16'(i));
    do_read(4'd6, 4'd15, d1, d2);
    n_cmp++;
    if ({d1, d2} !== {16'hC006, 16'hC00F}) begin
      n_err++;
      $display("FAIL clear_prefill: R6=%h R15=%h required c006 c00f", d1, d2);
    end
    send_cmd(2'b11, 4'd0, 4'd0, 16'h0);
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) @(negedge clk);
      n_cmp++;
      if (cmd_ready !== (i == 16)) begin
        n_err++;
        $display("FAIL clear_ready_e%0d: cmd_ready=%b required %0d", i, cmd_ready, (i == 16));
      end
      n_cmp++;
      if (rf_wen !== (i < 16)) begin
        n_err++;
        $display("FAIL clear_wen_e%0d: rf_wen=%b required %0d", i, rf_wen, (i < 16));
      end
      if (i < 16) begin
        n_cmp++;
        if ({rf_wadr, rf_din} !== {4'(i), 16'h0}) begin
          n_err++;
          $display("FAIL clear_wadr_e%0d: wadr=%0d din=%h required %0d 0000", i, rf_wadr, rf_din, i);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      do_read(4'(i), 4'(15 - i), d1, d2);
      n_cmp++;
      if ({d1, d2} !== 32'h0) begin
        n_err++;
        $display("FAIL clear_read_%0d: R%0d=%h R%0d=%h required 0", i, i, d1, 15 - i, d2);
      end
    end
  endtask

  task automatic test_reset_mid_clear;
    logic [15:0] d1, d2;
    for (int i = 0; i < 16; i++) send_cmd(2'b01, 4'(i), 4'd0, 16'h5A00 + 16'(i));
    do_read(4'd1, 4'd2, d1, d2);
    send_cmd(2'b11, 4'd0, 4'd0, 16'h0);
    repeat (4) @(negedge clk);
    n_cmp++;
    if ({rf_wen, rf_wadr} !== {1'b1, 4'd4}) begin
      n_err++;
      $display("FAIL rstclr_pre: wen=%b wadr=%0d required 1 4", rf_wen, rf_wadr);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({cmd_ready, rsp_valid, rf_wen} !== 3'b100) begin
      n_err++;
      $display("FAIL rstclr_ctrl: ready/rsp_valid/wen=%b required 100", {cmd_ready, rsp_valid, rf_wen});
    end
    n_cmp++;
    if ({rsp_data1, rsp_data2, rf_din, rf_wadr, rf_radr1, rf_radr2} !== 60'h0) begin
      n_err++;
      $display("FAIL rstclr_data: d1=%h d2=%h din=%h wadr=%h radr=%h/%h required all 0",
               rsp_data1, rsp_data2, rf_din, rf_wadr, rf_radr1, rf_radr2);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({cmd_ready, rf_wen} !== 2'b10) begin
        n_err++;
        $display("FAIL rstclr_idle_%0d: ready/wen=%b required 10", i, {cmd_ready, rf_wen});
      end
    end
    for (int i = 0; i < 16; i += 2) begin
      do_read(4'(i), 4'(i + 1), d1, d2);
      n_cmp++;
      if (d1 !== ((i < 5) ? 16'h0 : 16'h5A00 + 16'(i))
          || d2 !== ((i + 1 < 5) ? 16'h0 : 16'h5A00 + 16'(i + 1))) begin
        n_err++;
        $display("FAIL rstclr_reg_%0d: R%0d=%h R%0d=%h required %h %h", i, i, d1, i + 1, d2,
                 (i < 5) ? 16'h0 : 16'h5A00 + 16'(i), (i + 1 < 5) ? 16'h0 : 16'h5A00 + 16'(i + 1));
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_read_basic;
    test_write_then_read;
    test_swap;
    test_clear;
    test_reset_mid_clear;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
